lmem_srq_combined_pipe: RTL and testbench

//  LLR (bit-node) memory of the layered QC-LDPC decoder for the CCSDS C2 code (Z=511, Nb=16, 2 layers, circulant weight 2).
//  - Loads channel LLRs.
//  - Serves P=26 circulant rows per cycle to the RCU pipeline, with the layer's circulant shifts applied, and accepts the updated LLRs back.
//  - Unloads hard decisions of the 14 systematic blocks.

---
 rtl/lmem_pkg.sv | 60 ++++++
 rtl/lmem_rot_slice.sv | 28 ++
 rtl/lmem_srq_combined_pipe.sv | 151 +++++++++++++++
 tb/tb_lmem_srq_combined_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lmem_pkg.sv
// Shared constants, types and helpers for the LLR memory of the layered
// QC-LDPC decoder (CCSDS C2 code: Z=511, 16 block columns, 2 layers,
// circulant weight 2).
//   - geometry constants (LLR width, rows per cycle, circulant size, ...)
//   - SHIFT[layer][column][copy] circulant shift table
//   - ctrl_t: registered control word of the input stage
//   - sat(): clamp an LLR to +-MAX_VAL
//   - rot_index(): (row + shift) mod Z for row < Z
package lmem_pkg;

    localparam int W          = 6;   // LLR width, two's complement
    localparam int P          = 26;  // circulant rows served per cycle
    localparam int Z          = 511; // circulant size
    localparam int Nb         = 16;  // block columns
    localparam int Kb         = 14;  // systematic block columns
    localparam int Wt         = 2;   // circulant weight
    localparam int P_LAST     = 17;  // valid rows in the last row group
    localparam int HDWIDTH    = 32;  // hard decisions per column per unload
    localparam int AW         = 5;   // address width
    localparam int LOAD_W     = 32;  // LLRs per column per load line
    localparam int LOAD_LINES = 17;  // load lines covering Z (17*32 >= 511)

    localparam logic signed [W-1:0] MAX_VAL = 6'sb011111;

    localparam int SHIFT [2][Nb][Wt] = '{
        '{ '{0, 176}, '{12, 239}, '{0, 352}, '{24, 431},
           '{0, 392}, '{151, 409}, '{0, 351}, '{9, 359},
           '{0, 307}, '{53, 329}, '{0, 207}, '{18, 281},
           '{0, 399}, '{202, 457}, '{0, 247}, '{36, 261} },
        '{ '{99, 471}, '{130, 473}, '{198, 435}, '{260, 478},
           '{215, 420}, '{282, 481}, '{48, 396}, '{193, 445},
           '{273, 430}, '{302, 451}, '{96, 379}, '{191, 386},
           '{244, 467}, '{364, 470}, '{51, 382}, '{192, 414} }
    };

    typedef struct packed {
        logic          rd_en;
        logic          rd_layer;
        logic          wr_en;
        logic          wr_layer;
        logic          loaden;
        logic          first;
        logic          unload_en;
        logic [AW-1:0] address;      // row group, shared by read and write-back
        logic [AW-1:0] unload_addr;
    } ctrl_t;

    // Only the most negative code (-32) lies outside +-MAX_VAL.
    function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] v);
        return (v < -MAX_VAL) ? -MAX_VAL : v;
    endfunction

    // Both operands are below Z, so one conditional subtract is a full mod.
    function automatic int rot_index(input int row, input int shift);
        int s;
        s = row + shift;
        return (s >= Z) ? s - Z : s;
    endfunction

endpackage

// File: rtl/lmem_rot_slice.sv
// One (column, copy) read lane: selects the P LLRs of a row group from one
// memory column with that column's circulant shift applied.
//   col     in   Z*W   column storage, element n at [n*W+:W]
//   address in   AW    row group; rows are address*P + p
//   layer   in   1     selects the shift table layer
//   fields  out  P*W   row p at [p*W+:W]; rows at or beyond Z read 0
module lmem_rot_slice
    import lmem_pkg::*;
#(
    parameter int COL = 0,
    parameter int K   = 0
) (
    input  logic [Z*W-1:0]  col,
    input  logic [AW-1:0]   address,
    input  logic            layer,
    output logic [P*W-1:0]  fields
);

    always_comb begin
        fields = '0;
        for (int p = 0; p < P; p++) begin
            if (int'(address) * P + p < Z)
                fields[p*W +: W] =
                    col[rot_index(int'(address) * P + p, SHIFT[layer][COL][K]) * W +: W];
        end
    end

endmodule

// File: rtl/lmem_srq_combined_pipe.sv
// LLR memory of the layered QC-LDPC decoder. Loads channel LLRs, serves P
// rows per cycle of every (column, copy) with the layer's circulant shift
// applied, accepts updated LLRs back, and unloads systematic hard decisions.
// All inputs are registered at the first edge; the array is accessed and the
// outputs are registered at the second edge (2-cycle latency).
//   clk                       in   1            rising-edge clock
//   rst                       in   1            asynchronous, active low
//   unload_HDout_vec_regout   out  Kb*HDWIDTH   hard decisions, column c at [c*32+:32]
//   rd_data_regout            out  P*Nb*Wt*W    field (c,k,p) at [((c*Wt+k)*P+p)*W+:W]
//   unload_en, unloadAddress  in   1, AW        unload request, 32-LLR group index
//   rd_en, rd_address, rd_layer in 1, AW, 1     read request; rd_address also
//                                               selects the write-back row group
//   load_data, loaden         in   32*Nb*W, 1   load line, column c element j at [(c*32+j)*W+:W]
//   wr_data, wr_en, wr_layer  in   P*Nb*Wt*W,1,1 write-back, same layout as read
//   firstprocessing_indicate  in   1            loads are accepted only while high
module lmem_srq_combined_pipe
    import lmem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    output logic [Kb*HDWIDTH-1:0]     unload_HDout_vec_regout,
    output logic [P*Nb*Wt*W-1:0]      rd_data_regout,
    input  logic                      unload_en,
    input  logic [AW-1:0]             unloadAddress,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_address,
    input  logic                      rd_layer,
    input  logic [LOAD_W*Nb*W-1:0]    load_data,
    input  logic                      loaden,
    input  logic [P*Nb*Wt*W-1:0]      wr_data,
    input  logic                      wr_en,
    input  logic                      wr_layer,
    input  logic                      firstprocessing_indicate
);

    ctrl_t                    ctrl_q;
    logic [LOAD_W*Nb*W-1:0]   load_data_q;
    logic [P*Nb*Wt*W-1:0]     wr_data_q;
    logic [AW-1:0]            load_cnt;
    logic [Z*W-1:0]           mem [Nb];
    logic [P*Nb*Wt*W-1:0]     rd_fields;
    logic [Kb*HDWIDTH-1:0]    unload_bits;
    int                       wr_idx [Nb][Wt][P];
    logic                     wr_ok [P];

    // Input stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q      <= '0;
            load_data_q <= '0;
            wr_data_q   <= '0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // sample their inputs from the same pre-edge state.
            ctrl_q      <= '{rd_en:       rd_en,
                             rd_layer:    rd_layer,
                             wr_en:       wr_en,
                             wr_layer:    wr_layer,
                             loaden:      loaden,
                             first:       firstprocessing_indicate,
                             unload_en:   unload_en,
                             address:     rd_address,
                             unload_addr: unloadAddress};
            load_data_q <= load_data;
            wr_data_q   <= wr_data;
        end
    end

    // Write-back addresses; wr_idx is only meaningful where wr_ok is set.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            wr_ok[p] = (int'(ctrl_q.address) * P + p) < Z;
            for (int c = 0; c < Nb; c++)
                for (int k = 0; k < Wt; k++)
                    wr_idx[c][k][p] = rot_index(int'(ctrl_q.address) * P + p,
                                                SHIFT[ctrl_q.wr_layer][c][k]);
        end
    end

    // Storage and load line counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is cleared by reset, so it is built from flops
            // rather than a RAM macro.
            for (int c = 0; c < Nb; c++)
                mem[c] <= '0;
            load_cnt <= '0;
        end else begin
            if (!ctrl_q.loaden)
                load_cnt <= '0;
            else if (load_cnt == AW'(LOAD_LINES - 1))
                load_cnt <= '0;
            else
                load_cnt <= load_cnt + 1'b1;

            if (ctrl_q.loaden) begin
                if (ctrl_q.first) begin
                    for (int c = 0; c < Nb; c++)
                        for (int j = 0; j < LOAD_W; j++)
                            if (int'(load_cnt) * LOAD_W + j < Z)
                                mem[c][(int'(load_cnt) * LOAD_W + j) * W +: W] <=
                                    sat(load_data_q[(c*LOAD_W + j)*W +: W]);
                end
            end else if (ctrl_q.wr_en) begin
                // Copy k=1 is assigned after k=0, so it wins on a collision.
                for (int k = 0; k < Wt; k++)
                    for (int c = 0; c < Nb; c++)
                        for (int p = 0; p < P; p++)
                            if (wr_ok[p])
                                mem[c][wr_idx[c][k][p] * W +: W] <=
                                    sat(wr_data_q[((c*Wt + k)*P + p)*W +: W]);
            end
        end
    end

    // Read lanes see the array state from before this edge's write.
    for (genvar c = 0; c < Nb; c++) begin : g_col
        for (genvar k = 0; k < Wt; k++) begin : g_copy
            lmem_rot_slice #(.COL(c), .K(k)) u_slice (
                .col     (mem[c]),
                .address (ctrl_q.address),
                .layer   (ctrl_q.rd_layer),
                .fields  (rd_fields[(c*Wt + k)*P*W +: P*W])
            );
        end
    end

    // Hard decision = sign bit; groups past the end of the column read 0.
    always_comb begin
        unload_bits = '0;
        for (int c = 0; c < Kb; c++)
            for (int j = 0; j < HDWIDTH; j++)
                if (int'(ctrl_q.unload_addr) * HDWIDTH + j < Z)
                    unload_bits[c*HDWIDTH + j] =
                        mem[c][(int'(ctrl_q.unload_addr) * HDWIDTH + j) * W + W - 1];
    end

    // Output registers hold while their request is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_regout          <= '0;
            unload_HDout_vec_regout <= '0;
        end else begin
            if (ctrl_q.rd_en)
                rd_data_regout <= rd_fields;
            if (ctrl_q.unload_en)
                unload_HDout_vec_regout <= unload_bits;
        end
    end

endmodule

// File: tb/tb_lmem_srq_combined_pipe.sv
// Directed bench for lmem_srq_combined_pipe. A reference array ref_mem
// tracks what the LLR storage should hold; read and unload results are
// compared against it field by field.
module tb_lmem_srq_combined_pipe;

    localparam int SH [2][16][2] = '{
        '{ '{0, 176}, '{12, 239}, '{0, 352}, '{24, 431},
           '{0, 392}, '{151, 409}, '{0, 351}, '{9, 359},
           '{0, 307}, '{53, 329}, '{0, 207}, '{18, 281},
           '{0, 399}, '{202, 457}, '{0, 247}, '{36, 261} },
        '{ '{99, 471}, '{130, 473}, '{198, 435}, '{260, 478},
           '{215, 420}, '{282, 481}, '{48, 396}, '{193, 445},
           '{273, 430}, '{302, 451}, '{96, 379}, '{191, 386},
           '{244, 467}, '{364, 470}, '{51, 382}, '{192, 414} }
    };

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [447:0]  unload_hd;
    logic [4991:0] rd_data;
    logic          unload_en = 1'b0;
    logic [4:0]    unload_address = '0;
    logic          rd_en = 1'b0;
    logic [4:0]    rd_address = '0;
    logic          rd_layer = 1'b0;
    logic [3071:0] load_data = '0;
    logic          loaden = 1'b0;
    logic [4991:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_layer = 1'b0;
    logic          first_proc = 1'b0;

    int ref_mem [16][511];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmem_srq_combined_pipe dut (
        .clk                      (clk),
        .rst                      (rst),
        .unload_HDout_vec_regout  (unload_hd),
        .rd_data_regout           (rd_data),
        .unload_en                (unload_en),
        .unloadAddress            (unload_address),
        .rd_en                    (rd_en),
        .rd_address               (rd_address),
        .rd_layer                 (rd_layer),
        .load_data                (load_data),
        .loaden                   (loaden),
        .wr_data                  (wr_data),
        .wr_en                    (wr_en),
        .wr_layer                 (wr_layer),
        .firstprocessing_indicate (first_proc)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < -31) ? -31 : v;
    endfunction

    function automatic int fld(input int c, input int k, input int p);
        logic [5:0] v;
        v = rd_data[((c*2 + k)*26 + p)*6 +: 6];
        return int'($signed(v));
    endfunction

    // Compare the current read output against ref_mem for group a.
    task automatic check_read(input int a, input int layer, input string tag);
        int row;
        int exp;
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 26; p++) begin
                    row = a*26 + p;
                    exp = (row < 511) ? ref_mem[c][(row + SH[layer][c][k]) % 511] : 0;
                    check($sformatf("%s a%0d l%0d c%0d k%0d p%0d", tag, a, layer, c, k, p),
                          fld(c, k, p), exp);
                end
    endtask

    task automatic do_read(input int a, input int layer, input string tag);
        @(negedge clk);
        rd_en = 1'b1; rd_address = 5'(a); rd_layer = 1'(layer);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check_read(a, layer, tag);
    endtask

    task automatic model_write(input int a, input int layer, input int val);
        int row;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 16; c++)
                for (int p = 0; p < 26; p++) begin
                    row = a*26 + p;
                    if (row < 511)
                        ref_mem[c][(row + SH[layer][c][k]) % 511] = sat(val);
                end
    endtask

    task automatic fill_wr(input int val);
        for (int i = 0; i < 832; i++)
            wr_data[i*6 +: 6] = 6'(val);
    endtask

    task automatic do_write(input int a, input int layer, input int val);
        @(negedge clk);
        fill_wr(val);
        wr_en = 1'b1; rd_address = 5'(a); wr_layer = 1'(layer);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        model_write(a, layer, val);
    endtask

    // kind 0: L[c][n] = (n mod 31) - 15; otherwise every element = cval.
    // with_wr raises a write-back of 7 to group 0 together with line 0.
    task automatic do_load(input int nlines, input int kind, input int cval,
                           input bit fp, input bit with_wr);
        int n;
        int v;
        for (int m = 0; m < nlines; m++) begin
            @(negedge clk);
            loaden = 1'b1; first_proc = fp;
            if (with_wr && m == 0) begin
                fill_wr(7); wr_en = 1'b1; rd_address = '0; wr_layer = 1'b0;
            end else begin
                wr_en = 1'b0;
            end
            for (int c = 0; c < 16; c++)
                for (int j = 0; j < 32; j++) begin
                    n = m*32 + j;
                    v = (kind == 0) ? (n % 31) - 15 : cval;
                    load_data[(c*32 + j)*6 +: 6] = 6'(v);
                    if (fp && n < 511)
                        ref_mem[c][n] = sat(v);
                end
        end
        @(negedge clk);
        loaden = 1'b0; wr_en = 1'b0; first_proc = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_unload(input int addr, input string tag);
        logic [31:0] exp;
        int n;
        for (int c = 0; c < 14; c++) begin
            exp = '0;
            for (int j = 0; j < 32; j++) begin
                n = addr*32 + j;
                if (addr < 16 && n < 511)
                    exp[j] = (ref_mem[c][n] < 0);
            end
            check($sformatf("%s addr%0d c%0d", tag, addr, c),
                  int'(unload_hd[c*32 +: 32]), int'(exp));
        end
    endtask

    task automatic do_unload(input int addr, input string tag);
        @(negedge clk);
        unload_en = 1'b1; unload_address = 5'(addr);
        @(negedge clk);
        unload_en = 1'b0;
        @(negedge clk);
        check_unload(addr, tag);
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int n = 0; n < 511; n++)
                ref_mem[c][n] = 0;

        repeat (3) @(negedge clk);
        check("reset rd_data nonzero", int'(|rd_data), 0);
        check("reset unload nonzero", int'(|unload_hd), 0);
        rst = 1'b1;
        do_read(0, 0, "rd_after_reset");

        // Ramp pattern, interior group and partial last group.
        do_load(17, 0, 0, 1'b1, 1'b0);
        do_read(3, 0, "rd_ramp");
        do_read(19, 1, "rd_last_group");

        // Write-back at the positive limit and at the -32 saturation point.
        do_write(5, 0, 31);
        do_read(5, 0, "rd_wr_pos");
        do_write(5, 0, -32);
        do_read(5, 0, "rd_wr_sat");

        // All-negative load (also saturates -32), then unload edges and hold.
        do_load(17, 1, -32, 1'b1, 1'b0);
        do_read(0, 1, "rd_neg");
        do_unload(15, "unload_last");
        check("unload15 c0 literal", int'(unload_hd[31:0]), int'(32'h7fff_ffff));
        do_read(4, 0, "rd_neg");
        check_unload(15, "unload_hold");
        do_unload(20, "unload_oob");
        check_read(4, 0, "rd_hold");

        // Same-cycle write and read: read sees old data, next read new data.
        @(negedge clk);
        fill_wr(9);
        wr_en = 1'b1; rd_en = 1'b1; rd_address = 5'd2; rd_layer = 1'b0; wr_layer = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check_read(2, 0, "rd_same_cycle_old");
        model_write(2, 0, 9);
        do_read(2, 0, "rd_same_cycle_new");

        // Load line 0 and write-back in the same cycle: load wins.
        do_load(1, 1, 3, 1'b1, 1'b1);
        do_read(0, 0, "rd_load_prio");

        // Load with firstprocessing_indicate low leaves storage untouched.
        do_load(17, 1, 5, 1'b0, 1'b0);
        do_read(2, 0, "rd_fp0");
        do_unload(3, "unload_fp0");

        // Reset in the middle of a load.
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            loaden = 1'b1; first_proc = 1'b1;
            for (int i = 0; i < 512; i++)
                load_data[i*6 +: 6] = 6'd3;
        end
        #2 rst = 1'b0;
        #1;
        check("midload rst rd_data nonzero", int'(|rd_data), 0);
        check("midload rst unload nonzero", int'(|unload_hd), 0);
        loaden = 1'b0; first_proc = 1'b0;
        for (int c = 0; c < 16; c++)
            for (int n = 0; n < 511; n++)
                ref_mem[c][n] = 0;
        @(negedge clk);
        rst = 1'b1;
        do_read(0, 0, "rd_after_midrst");
        do_read(19, 1, "rd_after_midrst");
        do_unload(0, "unload_after_midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
